fmadd_exp_arbiter: RTL and testbench
====================================

FMADD_EXP_ARBITER -- requirements
Module: fmadd_exp_arbiter

Interface
REQ-001 SHALL have parameter EXP, default 7, exponent MSB index; operand width is EXP+2 bits: sign at [EXP+1], biased exponent at [EXP:0].
REQ-002 SHALL have parameter BIAS, default 127, the exponent bias used for the overflow bound.
REQ-003 SHALL have parameter UFL_LIMIT, default 103, the raw-sum threshold below which underflow is flagged.
REQ-004 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- rst_l  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of any in-flight operation.
- reqN_valid  input  1  requester N (N=0,1) has operands.
- reqN_a, reqN_b  input  EXP+2  requester N operands.
- reqN_ready  output  1  requester N operands accepted this cycle.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_id  output  1  index of the requester that owns the result.
- resp_exp  output  EXP+2  raw sum a[EXP:0]+b[EXP:0].
- resp_sign  output  1  a[EXP+1] XOR b[EXP+1].
- resp_underflow  output  1  resp_exp < UFL_LIMIT.
- resp_overflow  output  1  resp_exp >= (2^(EXP+1)-1)+BIAS, i.e. 382 at default parameters.
- busy  output  1  state is not IDLE.

Function
REQ-005 SHALL implement a three-state FSM: IDLE, CALC, RESP.
REQ-006 In IDLE with flush=0 and at least one reqN_valid, SHALL assert exactly one reqN_ready combinationally, latch that requester's operands and id, and go to CALC.
REQ-007 Arbitration SHALL be round-robin: when both requesters are valid, grant the one not granted last; the pointer updates only on grant.
REQ-008 reqN_ready SHALL be 0 in CALC and RESP, and in any cycle with flush=1.
REQ-009 In CALC, SHALL zero-extend both exponent fields to EXP+2 bits, add them without truncation (max 510), compute the sign and both flags, register all results, set resp_valid=1 and go to RESP.
REQ-010 In RESP, SHALL hold resp_* stable while resp_ready=0; on resp_valid and resp_ready, SHALL clear resp_valid and return to IDLE.
REQ-011 Latency SHALL be: grant at cycle N, resp_valid high from cycle N+2; maximum throughput is one operation per 3 cycles.
REQ-012 flush=1 in any state SHALL force IDLE and clear resp_valid on the next edge; the arbitration pointer is unchanged.
REQ-013 resp_ready asserted in the same cycle as flush SHALL complete no handshake; the result is discarded.
REQ-014 resp_id, resp_exp, resp_sign and both flags SHALL keep their last registered value when resp_valid=0.

Reset
REQ-015 rst_l=0 SHALL asynchronously force: state=IDLE, arbitration pointer favouring requester 0, resp_valid=0, resp_id=0, resp_exp=0, resp_sign=0, resp_underflow=0, resp_overflow=0, busy=0.
REQ-016 A reset asserted mid-CALC or mid-RESP SHALL drop the operation with no response; the first grant after reset deassertion goes to requester 0.

Structure
REQ-017 The FSM state encoding, default EXP/BIAS/UFL_LIMIT and the overflow-bound constant SHALL reside in a shared FPU package.
REQ-018 The adder, sign and flag logic SHALL be one sub-module, fmadd_exp_sum_unit, instantiated once; arbitration and the FSM stay in the top module.

Verification
REQ-019 Single request: req0 a=0x07F, b=0x180 -> two cycles later resp_exp=255, resp_sign=1, resp_underflow=0, resp_overflow=0, resp_id=0.
REQ-020 Underflow/overflow: a=0x032, b=0x032 -> resp_exp=100, resp_underflow=1; a=0x0FF, b=0x0FF -> resp_exp=510, resp_overflow=1.
REQ-021 Contention: both valid continuously after reset -> grants alternate 0,1,0,1 and resp_id follows the same order.
REQ-022 Backpressure: resp_ready low for 3 cycles in RESP -> outputs stable, no new grant, then completion on the first resp_ready high.
REQ-023 Flush and reset: flush in CALC -> no resp_valid and IDLE next cycle; rst_l low in RESP -> resp_valid=0 immediately (asynchronously), and req0 is granted first afterward.

Source files
------------

// File: rtl/fmadd_exp_arbiter_pkg.sv
// Shared FPU definitions for the exponent-sum arbiter: FSM encoding,
// default exponent geometry, and the overflow bound.
package fmadd_exp_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } fsm_state_t;

    localparam int DEF_EXP       = 7;
    localparam int DEF_BIAS      = 127;
    localparam int DEF_UFL_LIMIT = 103;

    // Largest biased exponent plus the bias: the smallest raw sum that overflows.
    function automatic int ovf_bound(input int exp_msb, input int bias);
        return ((1 << (exp_msb + 1)) - 1) + bias;
    endfunction

    localparam int DEF_OVF_BOUND = ovf_bound(DEF_EXP, DEF_BIAS);

endpackage

// File: rtl/fmadd_exp_sum_unit.sv
// Raw exponent adder for a multiply-add: widened sum, product sign and
// underflow/overflow flags. Purely combinational.
module fmadd_exp_sum_unit
    import fmadd_exp_arbiter_pkg::*;
#(
    parameter int EXP       = DEF_EXP,
    parameter int BIAS      = DEF_BIAS,
    parameter int UFL_LIMIT = DEF_UFL_LIMIT
) (
    input  logic [EXP+1:0] a,
    input  logic [EXP+1:0] b,
    output logic [EXP+1:0] sum,
    output logic           sign,
    output logic           underflow,
    output logic           overflow
);

    localparam logic [31:0] UFL_L = 32'(UFL_LIMIT);
    localparam logic [31:0] OVF_L = 32'(ovf_bound(EXP, BIAS));

    logic [31:0] sum_ext;

    // One extra bit of headroom so two maximal exponents never wrap.
    assign sum       = {1'b0, a[EXP:0]} + {1'b0, b[EXP:0]};
    assign sum_ext   = 32'(sum);
    assign sign      = a[EXP+1] ^ b[EXP+1];
    assign underflow = sum_ext < UFL_L;
    assign overflow  = sum_ext >= OVF_L;

endmodule

// File: rtl/fmadd_exp_arbiter.sv
// Two-requester round-robin front end for the exponent-sum unit, with a
// registered single-entry response and flush/backpressure handling.
//
// state   | meaning
// IDLE    | waiting for a request; grants combinationally
// CALC    | operands latched, sum computed and registered this cycle
// RESP    | result presented, held until resp_ready
module fmadd_exp_arbiter
    import fmadd_exp_arbiter_pkg::*;
#(
    parameter int EXP       = DEF_EXP,
    parameter int BIAS      = DEF_BIAS,
    parameter int UFL_LIMIT = DEF_UFL_LIMIT
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           flush,
    input  logic           req0_valid,
    input  logic [EXP+1:0] req0_a,
    input  logic [EXP+1:0] req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [EXP+1:0] req1_a,
    input  logic [EXP+1:0] req1_b,
    output logic           req1_ready,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_id,
    output logic [EXP+1:0] resp_exp,
    output logic           resp_sign,
    output logic           resp_underflow,
    output logic           resp_overflow,
    output logic           busy
);

    fsm_state_t     state, state_nxt;
    logic           rr_ptr;
    logic           grant0, grant1, any_grant;
    logic [EXP+1:0] op_a, op_b;
    logic           op_id;
    logic [EXP+1:0] sum;
    logic           sum_sign, sum_ufl, sum_ovf;

    // rr_ptr = 1 means requester 1 wins the next tie.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ST_IDLE && !flush) begin
            if (req0_valid && req1_valid) begin
                grant0 = !rr_ptr;
                grant1 = rr_ptr;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign any_grant = grant0 | grant1;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (any_grant)  state_nxt = ST_CALC;
                ST_CALC:                 state_nxt = ST_RESP;
                ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
                default:                 state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        resp_valid = (state == ST_RESP);
        busy       = (state != ST_IDLE);
    end

    fmadd_exp_sum_unit #(
        .EXP       (EXP),
        .BIAS      (BIAS),
        .UFL_LIMIT (UFL_LIMIT)
    ) u_sum (
        .a         (op_a),
        .b         (op_b),
        .sum       (sum),
        .sign      (sum_sign),
        .underflow (sum_ufl),
        .overflow  (sum_ovf)
    );

    // Result registers only load in CALC, so they hold their value while idle.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rr_ptr         <= 1'b0;
            op_a           <= '0;
            op_b           <= '0;
            op_id          <= 1'b0;
            resp_id        <= 1'b0;
            resp_exp       <= '0;
            resp_sign      <= 1'b0;
            resp_underflow <= 1'b0;
            resp_overflow  <= 1'b0;
        end else begin
            if (any_grant) begin
                op_a   <= grant1 ? req1_a : req0_a;
                op_b   <= grant1 ? req1_b : req0_b;
                op_id  <= grant1;
                rr_ptr <= grant0;
            end
            if (state == ST_CALC && !flush) begin
                resp_id        <= op_id;
                resp_exp       <= sum;
                resp_sign      <= sum_sign;
                resp_underflow <= sum_ufl;
                resp_overflow  <= sum_ovf;
            end
        end
    end

endmodule

// File: tb/tb_fmadd_exp_arbiter.sv
// Scoreboard bench for fmadd_exp_arbiter: a transaction-level model predicts
// grants and results; a separate monitor checks every presented response.
module tb_fmadd_exp_arbiter;

    localparam int EXP       = 7;
    localparam int BIAS      = 127;
    localparam int UFL_LIMIT = 103;
    localparam int OVF_BOUND = ((1 << (EXP + 1)) - 1) + BIAS;

    typedef struct {
        int id;
        int e;
        int s;
        int u;
        int o;
        int due;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_l = 1'b0;
    logic           flush = 1'b0;
    logic           req0_valid = 1'b0, req1_valid = 1'b0;
    logic [EXP+1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic           req0_ready, req1_ready;
    logic           resp_valid;
    logic           resp_ready = 1'b1;
    logic           resp_id;
    logic [EXP+1:0] resp_exp;
    logic           resp_sign, resp_underflow, resp_overflow;
    logic           busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   free_cyc = 0;
    bit   last_grant = 1'b1;
    bit   in_rst = 1'b1;
    exp_t sb_q[$];

    fmadd_exp_arbiter #(.EXP(EXP), .BIAS(BIAS), .UFL_LIMIT(UFL_LIMIT)) dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .flush          (flush),
        .req0_valid     (req0_valid),
        .req0_a         (req0_a),
        .req0_b         (req0_b),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_a         (req1_a),
        .req1_b         (req1_b),
        .req1_ready     (req1_ready),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_exp       (resp_exp),
        .resp_sign      (resp_sign),
        .resp_underflow (resp_underflow),
        .resp_overflow  (resp_overflow),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic exp_t predict(input int id, input logic [EXP+1:0] a, input logic [EXP+1:0] b,
                                     input int now);
        exp_t r;
        r.id  = id;
        r.e   = int'(a[EXP:0]) + int'(b[EXP:0]);
        r.s   = int'(a[EXP+1] ^ b[EXP+1]);
        r.u   = (r.e < UFL_LIMIT) ? 1 : 0;
        r.o   = (r.e >= OVF_BOUND) ? 1 : 0;
        r.due = now + 2;
        return r;
    endfunction

    // Model: one outstanding op; tie goes to the requester not granted last.
    always begin
        bit busy_exp, g0, g1;
        @(negedge clk);
        #2;
        if (!in_rst && rst_l) begin
            busy_exp = (sb_q.size() != 0) || (cyc < free_cyc);
            chk("busy", 32'(busy), 32'(busy_exp));
            g0 = 1'b0;
            g1 = 1'b0;
            if (!busy_exp && !flush) begin
                if (req0_valid && req1_valid) begin
                    g0 = last_grant;
                    g1 = !last_grant;
                end else begin
                    g0 = req0_valid;
                    g1 = req1_valid;
                end
            end
            chk("req0_ready", 32'(req0_ready), 32'(g0));
            chk("req1_ready", 32'(req1_ready), 32'(g1));
            if (flush) begin
                sb_q.delete();
                free_cyc = cyc + 1;
            end else if (g0) begin
                sb_q.push_back(predict(0, req0_a, req0_b, cyc));
                last_grant = 1'b0;
            end else if (g1) begin
                sb_q.push_back(predict(1, req1_a, req1_b, cyc));
                last_grant = 1'b1;
            end
        end
    end

    // Monitor: compare whatever the DUT presents against the queue head.
    always begin
        bit rv_exp;
        @(negedge clk);
        if (!in_rst && rst_l) begin
            rv_exp = (sb_q.size() != 0) && (cyc >= sb_q[0].due);
            chk("resp_valid", 32'(resp_valid), 32'(rv_exp));
            if (resp_valid && rv_exp) begin
                chk("resp_id",        32'(resp_id),        32'(sb_q[0].id));
                chk("resp_exp",       32'(resp_exp),       32'(sb_q[0].e));
                chk("resp_sign",      32'(resp_sign),      32'(sb_q[0].s));
                chk("resp_underflow", 32'(resp_underflow), 32'(sb_q[0].u));
                chk("resp_overflow",  32'(resp_overflow),  32'(sb_q[0].o));
                if (resp_ready && !flush) begin
                    void'(sb_q.pop_front());
                    free_cyc = cyc + 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int id, input logic [EXP+1:0] a, input logic [EXP+1:0] b);
        bit got = 1'b0;
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req1_valid = 1'b0;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req0_valid = 1'b0;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (id == 0) ? req0_ready : req1_ready;
        end
        if (!got) chk("grant_timeout", 32'(got), 32'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    function automatic logic [EXP+1:0] pick_op(input int target, input bit first, input int other);
        logic [EXP+1:0] r;
        r = '0;
        r[EXP+1] = 1'($urandom);
        if (first) begin
            int lo = (target > 255) ? target - 255 : 0;
            int hi = (target < 255) ? target : 255;
            r[EXP:0] = 8'($urandom_range(hi, lo));
        end else begin
            r[EXP:0] = 8'(target - other);
        end
        return r;
    endfunction

    initial begin
        logic [EXP+1:0] da[7];
        logic [EXP+1:0] db[7];
        int             did[7];
        int             targets[6];
        bit             seen;
        da = '{9'h07F, 9'h032, 9'h0FF, 9'h033, 9'h066, 9'h0FF, 9'h0FF};
        db = '{9'h180, 9'h032, 9'h0FF, 9'h034, 9'h000, 9'h17E, 9'h07F};
        did = '{0, 0, 1, 0, 1, 0, 1};
        targets = '{102, 103, 381, 382, 0, 510};

        repeat (3) step();
        #2 rst_l = 1'b1;
        in_rst = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_exp",   32'(resp_exp),   32'd0);
        chk("rst_resp_flags", 32'({resp_id, resp_sign, resp_underflow, resp_overflow}), 32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        step();

        // Directed operands: single request, threshold edges on both flags.
        foreach (da[i]) begin
            send(did[i], da[i], db[i]);
            repeat (3) step();
        end

        // Contention: both valid continuously.
        req0_a = 9'h010; req0_b = 9'h020; req1_a = 9'h1F0; req1_b = 9'h001;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (24) step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step();

        // Backpressure with a competing requester waiting.
        resp_ready = 1'b0;
        send(1, 9'h081, 9'h055);
        req0_valid = 1'b1; req0_a = 9'h011; req0_b = 9'h022;
        repeat (5) step();
        resp_ready = 1'b1;
        repeat (6) step();
        req0_valid = 1'b0;
        repeat (4) step();

        // Flush while idle with a request, then flush in CALC, then in RESP with resp_ready.
        flush = 1'b1; req1_valid = 1'b1;
        step();
        flush = 1'b0;
        send(1, 9'h040, 9'h040);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (3) step();
        send(0, 9'h0AA, 9'h055);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (3) step();

        // Reset during RESP after req0 was granted last.
        resp_ready = 1'b0;
        send(0, 9'h07F, 9'h180);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = resp_valid;
        end
        chk("resp_before_reset", 32'(seen), 32'd1);
        @(posedge clk);
        #3;
        in_rst = 1'b1;
        rst_l = 1'b0;
        #1;
        chk("async_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("async_rst_busy",       32'(busy),       32'd0);
        chk("async_rst_resp_exp",   32'(resp_exp),   32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_l = 1'b1;
        sb_q.delete();
        free_cyc = 0;
        last_grant = 1'b1;
        in_rst = 1'b0;
        resp_ready = 1'b1;
        step();
        req0_a = 9'h001; req0_b = 9'h002; req1_a = 9'h003; req1_b = 9'h004;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("first_grant_after_reset", 32'({req1_ready, req0_ready}), 32'd1);
        repeat (8) step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step();

        // Randomized traffic with occasional flush/backpressure and flag-edge operands.
        repeat (1500) begin
            step();
            req0_valid = ($urandom_range(9, 0) < 6);
            req1_valid = ($urandom_range(9, 0) < 6);
            resp_ready = ($urandom_range(9, 0) < 7);
            flush      = ($urandom_range(29, 0) == 0);
            if ($urandom_range(3, 0) == 0) begin
                int t = targets[$urandom_range(5, 0)];
                req0_a = pick_op(t, 1'b1, 0);
                req0_b = pick_op(t, 1'b0, int'(req0_a[EXP:0]));
            end else begin
                req0_a = (EXP+2)'($urandom);
                req0_b = (EXP+2)'($urandom);
            end
            req1_a = (EXP+2)'($urandom);
            req1_b = (EXP+2)'($urandom);
        end

        step();
        req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1;
        repeat (10) step();
        chk("drain_queue", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
